// File: rtl/clock_set_ctrl_pkg.sv
// Shared encodings, BCD limits and small BCD helpers for the clock time-setting controller.
package clock_set_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2
  } mode_e;

  localparam logic [3:0] MIN_TENS_MAX = 4'd5;
  localparam logic [3:0] DIGIT_MAX    = 4'd9;

  localparam int BLINK_HOUR_BIT = 1;
  localparam int BLINK_MIN_BIT  = 0;

  // An out-of-range minute snapshot is replaced by 00 rather than edited as garbage.
  function automatic logic [7:0] bcd_min_sanitize(input logic [7:0] m);
    if ((m[7:4] > MIN_TENS_MAX) || (m[3:0] > DIGIT_MAX)) begin
      return 8'h00;
    end else begin
      return m;
    end
  endfunction

  function automatic logic [7:0] bcd_min_inc(input logic [7:0] m);
    logic [7:0] r;
    if (m[3:0] == DIGIT_MAX) begin
      if (m[7:4] == MIN_TENS_MAX) begin
        r = 8'h00;
      end else begin
        r = {m[7:4] + 4'd1, 4'd0};
      end
    end else begin
      r = {m[7:4], m[3:0] + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/clock_set_ctrl_btn_debounce.sv
// Push-button front end: 2-flop synchroniser, stability counter and a one-clk press pulse
// on the debounced rising edge.
module btn_debounce #(
  parameter logic [15:0] DB_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  logic        sync1_q, sync2_q;
  logic        db_q, db_d;
  logic [15:0] cnt_q, cnt_d;
  logic        press_q, press_d;

  // Debounced level flips only after DB_CYCLES consecutive cycles of disagreement.
  always_comb begin
    cnt_d = 16'd0;
    db_d  = db_q;
    if (sync2_q == db_q) begin
      cnt_d = 16'd0;
    end else if (cnt_q == DB_CYCLES - 16'd1) begin
      db_d  = sync2_q;
      cnt_d = 16'd0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
    press_d = db_d & ~db_q;
  end

  // Synchroniser, debounce and press registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= 16'd0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: RUN / SET_HOUR / SET_MIN FSM editing a shadow hour/minute,
// with blink mask, inactivity timeout and a one-cycle load back into the datapath.
module clock_set_ctrl
  import clock_set_ctrl_pkg::*;
#(
  parameter logic [15:0] DB_CYCLES = 16'd50000,
  parameter int          HOUR_MOD  = 16,
  parameter int          TIMEOUT_S = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic [3:0] cur_hour,
  input  logic [7:0] cur_min,
  output logic       run_en,
  output logic       load,
  output logic [3:0] set_hour,
  output logic [7:0] set_min,
  output logic [1:0] blink,
  output logic [1:0] mode
);

  localparam int             TO_W    = $clog2(TIMEOUT_S + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_S - 1);

  logic mode_press, inc_press;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
    .clk(clk), .reset(reset), .btn_raw(mode_btn), .press(mode_press)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_inc (
    .clk(clk), .reset(reset), .btn_raw(inc_btn), .press(inc_press)
  );

  mode_e           state_q, state_d;
  logic [3:0]      set_hour_q, set_hour_d;
  logic [7:0]      set_min_q, set_min_d;
  logic            load_q, load_d;
  logic            run_en_q, run_en_d;
  logic [1:0]      blink_q, blink_d;
  logic            phase_q, phase_d;
  logic [TO_W-1:0] to_q, to_d;

  // Next state, shadow edits, blink phase and timeout; mode press takes priority over inc.
  always_comb begin
    state_d    = state_q;
    set_hour_d = set_hour_q;
    set_min_d  = set_min_q;
    load_d     = 1'b0;
    phase_d    = phase_q;
    to_d       = to_q;
    case (state_q)
      MODE_RUN: begin
        phase_d = 1'b0;
        to_d    = '0;
        if (mode_press) begin
          set_hour_d = ({28'd0, cur_hour} >= HOUR_MOD) ? 4'd0 : cur_hour;
          set_min_d  = bcd_min_sanitize(cur_min);
          state_d    = MODE_SET_HOUR;
        end else begin
          state_d = MODE_RUN;
        end
      end
      MODE_SET_HOUR: begin
        if (mode_press) begin
          state_d = MODE_SET_MIN;
          phase_d = 1'b0;
          to_d    = '0;
        end else if (inc_press) begin
          set_hour_d = ({28'd0, set_hour_q} == HOUR_MOD - 1) ? 4'd0 : set_hour_q + 4'd1;
          to_d       = '0;
        end else if (tick_1hz) begin
          if (to_q == TO_LAST) begin
            state_d = MODE_RUN;
            phase_d = 1'b0;
            to_d    = '0;
          end else begin
            to_d    = to_q + TO_W'(1);
            phase_d = ~phase_q;
          end
        end else begin
          to_d = to_q;
        end
      end
      MODE_SET_MIN: begin
        if (mode_press) begin
          load_d  = 1'b1;
          state_d = MODE_RUN;
          phase_d = 1'b0;
          to_d    = '0;
        end else if (inc_press) begin
          set_min_d = bcd_min_inc(set_min_q);
          to_d      = '0;
        end else if (tick_1hz) begin
          if (to_q == TO_LAST) begin
            state_d = MODE_RUN;
            phase_d = 1'b0;
            to_d    = '0;
          end else begin
            to_d    = to_q + TO_W'(1);
            phase_d = ~phase_q;
          end
        end else begin
          to_d = to_q;
        end
      end
      default: begin
        state_d = MODE_RUN;
        phase_d = 1'b0;
        to_d    = '0;
      end
    endcase

    // Counters stay frozen during the load cycle itself.
    run_en_d                 = (state_d == MODE_RUN) && !load_d;
    blink_d                  = 2'b00;
    blink_d[BLINK_HOUR_BIT]  = (state_d == MODE_SET_HOUR) && phase_d;
    blink_d[BLINK_MIN_BIT]   = (state_d == MODE_SET_MIN) && phase_d;
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= MODE_RUN;
      set_hour_q <= 4'd0;
      set_min_q  <= 8'h00;
      load_q     <= 1'b0;
      run_en_q   <= 1'b1;
      blink_q    <= 2'b00;
      phase_q    <= 1'b0;
      to_q       <= '0;
    end else begin
      state_q    <= state_d;
      set_hour_q <= set_hour_d;
      set_min_q  <= set_min_d;
      load_q     <= load_d;
      run_en_q   <= run_en_d;
      blink_q    <= blink_d;
      phase_q    <= phase_d;
      to_q       <= to_d;
    end
  end

  assign run_en   = run_en_q;
  assign load     = load_q;
  assign set_hour = set_hour_q;
  assign set_min  = set_min_q;
  assign blink    = blink_q;
  assign mode     = state_q;

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
Time-setting controller for the seconds/minutes/hours clock datapath. Debounces two push-buttons (mode, inc) and steps an FSM through RUN, SET_HOUR and SET_MIN. While setting, it freezes the counters, edits a shadow copy of hour and minute, and drives a blink mask to the 7-segment drivers. On exit it issues a one-cycle load that writes the edited time into the counters and clears seconds.

Parameters:
DB_CYCLES, 16'd50000, clk cycles a raw button must hold a stable level before its debounced level changes
HOUR_MOD, 16, hour field modulus; legal hour values are 0..HOUR_MOD-1 (max 16, 4-bit field)
TIMEOUT_S, 30, tick_1hz pulses without a button press before a SET state abandons edits

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
tick_1hz  in  1  one-clk-wide pulse once per second, from the seconds prescaler
mode_btn  in  1  raw mode button, asynchronous, active-high
inc_btn  in  1  raw increment button, asynchronous, active-high
cur_hour  in  4  live hour from the datapath
cur_min  in  8  live minute from the datapath, packed BCD {tens[7:4], units[3:0]}
run_en  out  1  1 = counters advance; 0 = counters frozen
load  out  1  one-cycle pulse: datapath loads set_hour/set_min and clears seconds to 00
set_hour  out  4  shadow hour
set_min  out  8  shadow minute, packed BCD
blink  out  2  bit1 = blank hour digit, bit0 = blank minute digits
mode  out  2  0 = RUN, 1 = SET_HOUR, 2 = SET_MIN

Behaviour:
- Reset (reset=0, asynchronous): state RUN; run_en=1; load=0; set_hour=0; set_min=8'h00; blink=2'b00; mode=0; synchronisers, debounce counters and timeout counter cleared.
- Button input path:
  - Each button passes through a 2-flop synchroniser, then a debounce counter.
  - The counter reloads whenever the synchronised input equals the debounced level. Otherwise it counts; the debounced level flips after DB_CYCLES consecutive mismatching cycles.
  - A press event is a one-clk pulse on the debounced rising edge. Releases generate nothing. There is no auto-repeat.
- RUN:
  - run_en=1, blink=00.
  - mode press: set_hour<=cur_hour, set_min<=cur_min, go to SET_HOUR, run_en falls on the next cycle.
  - inc press is ignored.
- SET_HOUR:
  - inc press: set_hour <= (set_hour==HOUR_MOD-1) ? 0 : set_hour+1.
  - mode press: go to SET_MIN.
- SET_MIN:
  - inc press increments BCD: units 9 -> 0 with tens+1; 59 -> 00.
  - The hour is not affected by minute wrap.
  - mode press: load=1 for exactly one cycle, go to RUN. run_en=1 from the cycle after the load pulse, so the datapath sees load while still frozen.
- Blink, in SET states:
  - A blink phase flag toggles on each tick_1hz.
  - The field being edited is blanked while the phase is 1; the other field stays lit.
  - The phase flag is cleared on entry to each SET state.
- Timeout:
  - A counter increments on tick_1hz in SET states and clears on any press or state change.
  - When it reaches TIMEOUT_S, return to RUN with no load pulse; the live time is preserved, as if the edit was cancelled.
- Simultaneous events:
  - mode and inc presses in the same cycle: mode wins, inc is dropped.
  - A press and the timeout in the same cycle: the press wins and the counter clears.
- Invalid input: a cur_min snapshot with tens>5 or units>9 is forced to 00 on capture. A cur_hour >= HOUR_MOD is forced to 0.
- Reset asserted mid-SET: edits are discarded, no load pulse is issued, state returns to RUN.
- Unused state encoding 3 recovers to RUN on the next clk.

Decomposition:
- Shared package/include:
  - mode encodings (MODE_RUN=0, MODE_SET_HOUR=1, MODE_SET_MIN=2);
  - BCD limit constants (MIN_TENS_MAX=5, DIGIT_MAX=9);
  - blink bit positions.
- One sub-module, btn_debounce (synchroniser, debounce counter, rising-edge press pulse; DB_CYCLES parameter). It is instantiated twice.

Test Plan:
- Reset and debounce (DB_CYCLES=4 in sim): hold reset=0 and toggle all inputs -> all outputs stay at reset values. Release reset, then bounce mode_btn 1-0-1 within 3 cycles -> no press. Hold 1 for 4 cycles -> exactly one press; mode goes 0->1.
- Hour wrap: cur_hour=14, HOUR_MOD=16; enter SET_HOUR, press inc twice -> set_hour 15 then 0. run_en=0 throughout.
- Minute BCD and load: cur_min=8'h58; mode, mode, inc, inc, inc -> set_min 59, 00, 01. mode -> load high for exactly 1 cycle with set_min=8'h01; run_en=1 the following cycle.
- Blink: in SET_MIN, pulse tick_1hz three times -> blink 01, 00, 01; the hour bit stays 0.
- Timeout (TIMEOUT_S=3): enter SET_HOUR, press inc once, then 3 ticks with no presses -> mode=0, load never asserted, run_en=1.
- Collision and mid-edit reset: mode and inc press in the same cycle in SET_HOUR -> SET_MIN entered, set_hour unchanged. Then assert reset -> RUN, no load, set_min=00.
